uart_block_sequencer: RTL and testbench
=======================================

# uart_block_sequencer

Controller that drains the byte-wide UART receive FIFO, frames the incoming byte stream into 512-bit message blocks and hands each block to the SHA-1 core over a valid/ready handshake. Sits between the UART driver's RX FIFO read port (rd_uart / rx_empty / r_data) and the hash engine's block input. It checks per-block headers, tracks message first/last boundaries and aborts a stalled block on an inter-byte timeout.

## Interface
- BLOCK_BYTES, 64, payload bytes per block; block width = 8*BLOCK_BYTES.
- TIMEOUT_CYCLES, 1_000_000, maximum clk cycles of continuous rx_empty allowed inside a block payload.
- CNT_W, 20, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rx_empty  in  1  RX FIFO empty flag.
- r_data  in  8  RX FIFO read data; valid the cycle after rd_uart.
- rd_uart  out  1  RX FIFO read strobe, one-cycle pulse.
- blk_data  out  8*BLOCK_BYTES  assembled block; first payload byte in bits [511:504].
- blk_first  out  1  block is the first of a message; qualified by blk_valid.
- blk_last  out  1  block is the last of a message; qualified by blk_valid.
- blk_valid  out  1  block presented to the hash core.
- blk_ready  in  1  hash core accepts the block.
- busy  out  1  high in every state except S_IDLE.
- err  out  1  one-cycle error pulse.
- err_code  out  2  cause, held until the next err: 01 bad header, 10 sequence error, 11 timeout.

## Operation
- Every block on the wire is one header byte followed by BLOCK_BYTES payload bytes.
- Header byte: bit0 = last, bit1 = first, bits[7:2] must be 0.
- Internal flag in_msg: set on an accepted header with first=1; cleared when a last=1 block is accepted by the core, and on any error.
- FSM states:
  - S_IDLE: if !rx_empty, pulse rd_uart and go to S_HDR_CAP.
  - S_HDR_CAP: sample r_data, then one of:
    - bits[7:2] != 0: err, code 01.
    - first=1 while in_msg, or first=0 while !in_msg: err, code 10.
    - otherwise latch first/last, clear byte index and go to S_PAY_WAIT.
    - On either error: byte discarded, in_msg cleared, back to S_IDLE.
  - S_PAY_WAIT: if !rx_empty, pulse rd_uart, clear the timeout counter and go to S_PAY_CAP. Else increment the timeout counter. When it reaches TIMEOUT_CYCLES-1: err, code 11; discard the partial block, clear in_msg, go to S_IDLE.
  - S_PAY_CAP: shift r_data into the block register MSB-first and increment the byte index. At index BLOCK_BYTES-1 go to S_PRESENT, else S_PAY_WAIT.
  - S_PRESENT: blk_valid=1. blk_data, blk_first and blk_last are stable until blk_ready. On blk_valid && blk_ready, go to S_IDLE; if last, clear in_msg.
- Only one FIFO read is in flight at a time: rd_uart is never asserted in consecutive cycles.
- Byte index is 0..BLOCK_BYTES-1 and never wraps; the timeout counter saturates and does not wrap.

## Timing
- Reset (rst=0, asynchronous): state S_IDLE; rd_uart, blk_valid, blk_first, blk_last, busy and err are 0; err_code=00; blk_data=0; counters and in_msg are 0.
- Reset asserted mid-block drops the partial block silently, with no err. Bytes already in the FIFO are left untouched; the FIFO's own reset is shared.
- Cost per byte is 2 cycles (read, capture) when the FIFO is non-empty.
- Minimum latency from the header read to blk_valid is 1 + 1 + 2*BLOCK_BYTES = 130 cycles.
- blk_valid may rise without waiting for blk_ready. The next header read starts the cycle after acceptance.
- err pulses in the cycle following the detecting state and coincides with the return to S_IDLE.

## Structure
- Shared package sha1_uart_pkg holds:
  - state enum: S_IDLE, S_HDR_CAP, S_PAY_WAIT, S_PAY_CAP, S_PRESENT;
  - err_code constants: ERR_NONE=00, ERR_HDR=01, ERR_SEQ=10, ERR_TIMEOUT=11;
  - header bit positions: HDR_LAST=0, HDR_FIRST=1.
- One sub-module, block_shift_reg: a 512-bit MSB-first byte shifter with clear and shift-enable.
- FSM, counters and the flags stay in the top module.

## Test plan
- Single-block message: header 0x03, then bytes 0x00..0x3F -> one blk_valid with first=1, last=1, blk_data[511:504]=0x00, blk_data[7:0]=0x3F, no err.
- Two-block message: headers 0x02 then 0x01 with blk_ready held low for 50 cycles -> blk_data stable throughout the stall; second block has first=0, last=1; the 0x01 header is not read until after the first acceptance.
- Bad header 0x80 -> err pulse with err_code=01, no blk_valid, FSM back to S_IDLE; a following valid 0x03 block is processed normally.
- Sequence error: header 0x01 with no message open -> err_code=10. Separately, header 0x02 followed by 64 bytes and then header 0x02 again -> err_code=10 at the second header.
- Timeout with TIMEOUT_CYCLES=100: header 0x03 plus 10 bytes, then rx_empty held high -> err_code=11 exactly 100 cycles after the last rd_uart capture, no blk_valid, busy=0.
- Assert rst at byte 30 of a block, then send a fresh 0x03 block -> outputs at reset values, no err, fresh block delivered intact.

Source files
------------

// File: rtl/sha1_uart_pkg.sv
// Shared types and constants for the UART-to-SHA-1 block sequencer.
package sha1_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HDR_CAP  = 3'd1,
        S_PAY_WAIT = 3'd2,
        S_PAY_CAP  = 3'd3,
        S_PRESENT  = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_HDR     = 2'b01;
    localparam logic [1:0] ERR_SEQ     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam int HDR_LAST  = 0;
    localparam int HDR_FIRST = 1;

endpackage

// File: rtl/block_shift_reg.sv
// Block assembly register: bytes enter at the bottom and move up, so the
// first byte shifted in ends up in the most significant byte.
module block_shift_reg #(
    parameter int BLOCK_BYTES = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     shift_en_i,
    input  logic [7:0]               din_i,
    output logic [8*BLOCK_BYTES-1:0] dout_o
);

    logic [8*BLOCK_BYTES-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else if (clear_i) begin
            data_q <= '0;
        end else if (shift_en_i) begin
            data_q <= {data_q[8*BLOCK_BYTES-9:0], din_i};
        end
    end

    assign dout_o = data_q;

endmodule

// File: rtl/uart_block_sequencer.sv
// Drains the UART RX FIFO, checks block headers and frames payload bytes into
// blocks for the SHA-1 core, with message first/last tracking and timeout abort.
module uart_block_sequencer
    import sha1_uart_pkg::*;
#(
    parameter int BLOCK_BYTES    = 64,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CNT_W          = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_empty,
    input  logic [7:0]               r_data,
    output logic                     rd_uart,
    output logic [8*BLOCK_BYTES-1:0] blk_data,
    output logic                     blk_first,
    output logic                     blk_last,
    output logic                     blk_valid,
    input  logic                     blk_ready,
    output logic                     busy,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic [2:0]               dbg_state
);

    localparam int IDX_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_BYTES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] to_cnt_q;
    logic             in_msg_q;
    logic             first_q;
    logic             last_q;
    logic             blk_valid_q;
    logic             busy_q;
    logic             err_q;
    logic [1:0]       err_code_q;

    logic [CNT_W-1:0] to_cnt_d;
    logic             hdr_first;
    logic             hdr_last;
    logic             hdr_rsvd_bad;
    logic             hdr_seq_bad;
    logic             hdr_ok;
    logic             timeout_hit;
    logic             shift_en;
    logic             shift_clr;

    always_comb begin
        hdr_first    = r_data[HDR_FIRST];
        hdr_last     = r_data[HDR_LAST];
        hdr_rsvd_bad = |r_data[7:2];
        // A new message may only open when none is open, and vice versa.
        hdr_seq_bad  = (hdr_first == in_msg_q);
        hdr_ok       = (state_q == S_HDR_CAP) && !hdr_rsvd_bad && !hdr_seq_bad;
        to_cnt_d     = (to_cnt_q == CNT_MAX) ? to_cnt_q : to_cnt_q + CNT_W'(1);
        timeout_hit  = (state_q == S_PAY_WAIT) && rx_empty && (to_cnt_d >= TO_LAST);
        shift_en     = (state_q == S_PAY_CAP);
        shift_clr    = hdr_ok || timeout_hit;
    end

    // One read in flight: every read state is followed by a capture state.
    assign rd_uart = rst && !rx_empty &&
                     ((state_q == S_IDLE) || (state_q == S_PAY_WAIT));

    // Block handshake: blk_valid rises when the block is complete and holds with
    // blk_data/blk_first/blk_last stable; transfer happens on blk_valid && blk_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            to_cnt_q    <= '0;
            in_msg_q    <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            blk_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rx_empty) begin
                        state_q <= S_HDR_CAP;
                        busy_q  <= 1'b1;
                    end
                end
                S_HDR_CAP: begin
                    if (hdr_rsvd_bad || hdr_seq_bad) begin
                        err_q      <= 1'b1;
                        err_code_q <= hdr_rsvd_bad ? ERR_HDR : ERR_SEQ;
                        in_msg_q   <= 1'b0;
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                    end else begin
                        first_q  <= hdr_first;
                        last_q   <= hdr_last;
                        in_msg_q <= 1'b1;
                        idx_q    <= '0;
                        to_cnt_q <= '0;
                        state_q  <= S_PAY_WAIT;
                    end
                end
                S_PAY_WAIT: begin
                    if (!rx_empty) begin
                        to_cnt_q <= '0;
                        state_q  <= S_PAY_CAP;
                    end else if (timeout_hit) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                        to_cnt_q   <= '0;
                        in_msg_q   <= 1'b0;
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                    end else begin
                        to_cnt_q <= to_cnt_d;
                    end
                end
                S_PAY_CAP: begin
                    if (idx_q == IDX_LAST) begin
                        blk_valid_q <= 1'b1;
                        state_q     <= S_PRESENT;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        state_q <= S_PAY_WAIT;
                    end
                end
                S_PRESENT: begin
                    if (blk_ready) begin
                        blk_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        if (last_q) begin
                            in_msg_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    blk_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    block_shift_reg #(
        .BLOCK_BYTES(BLOCK_BYTES)
    ) u_shift (
        .clk_i     (clk),
        .rst_ni    (rst),
        .clear_i   (shift_clr),
        .shift_en_i(shift_en),
        .din_i     (r_data),
        .dout_o    (blk_data)
    );

    assign blk_first = first_q;
    assign blk_last  = last_q;
    assign blk_valid = blk_valid_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_block_sequencer.sv
// Directed bench for uart_block_sequencer: FIFO model, block scoreboard and
// error/timing checks with hand-computed expectations.
module tb_uart_block_sequencer;
    import sha1_uart_pkg::*;

    localparam int BB = 64;
    localparam int W  = 8 * BB;
    localparam int TO = 100;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rx_empty = 1'b1;
    logic [7:0]   r_data = 8'h00;
    logic         blk_ready = 1'b0;
    logic         rd_uart;
    logic [W-1:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic         blk_valid;
    logic         busy;
    logic         err;
    logic [1:0]   err_code;
    logic [2:0]   dbg_state;

    uart_block_sequencer #(
        .BLOCK_BYTES(BB),
        .TIMEOUT_CYCLES(TO),
        .CNT_W(7)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_empty (rx_empty),
        .r_data   (r_data),
        .rd_uart  (rd_uart),
        .blk_data (blk_data),
        .blk_first(blk_first),
        .blk_last (blk_last),
        .blk_valid(blk_valid),
        .blk_ready(blk_ready),
        .busy     (busy),
        .err      (err),
        .err_code (err_code),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // FIFO model and monitor state
    logic [7:0]   fifo_q[$];
    logic         rd_pending = 1'b0;
    int           cyc = 0;
    int           proto_bad = 0;
    logic         prev_rd = 1'b0;
    logic         prev_valid = 1'b0;
    int           rd_cyc_q[$];
    int           vrise_q[$];
    int           acc_n = 0;
    int           acc_cyc_q[$];
    logic [W-1:0] acc_data_q[$];
    logic         acc_first_q[$];
    logic         acc_last_q[$];
    int           err_cyc_q[$];
    logic [1:0]   err_code_q[$];
    logic         err_busy_q[$];
    logic [2:0]   err_state_q[$];

    // Scoreboard
    logic [W-1:0] exp_q[$];
    logic         exp_first_q[$];
    logic         exp_last_q[$];

    always @(negedge clk) begin
        cyc++;
        if (rd_uart) begin
            rd_cyc_q.push_back(cyc);
            if (prev_rd) proto_bad++;
            rd_pending = 1'b1;
        end
        if (blk_valid && !prev_valid) vrise_q.push_back(cyc);
        if (blk_valid && blk_ready) begin
            acc_n++;
            acc_cyc_q.push_back(cyc);
            acc_data_q.push_back(blk_data);
            acc_first_q.push_back(blk_first);
            acc_last_q.push_back(blk_last);
        end
        if (err) begin
            err_cyc_q.push_back(cyc);
            err_code_q.push_back(err_code);
            err_busy_q.push_back(busy);
            err_state_q.push_back(dbg_state);
        end
        prev_rd    = rd_uart;
        prev_valid = blk_valid;
    end

    always @(posedge clk) begin
        #2;
        if (rd_pending) begin
            if (fifo_q.size() == 0) proto_bad++;
            else r_data = fifo_q.pop_front();
            rd_pending = 1'b0;
        end
        rx_empty = (fifo_q.size() == 0);
    end

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] make_block(input logic [7:0] base);
        logic [W-1:0] b;
        b = '0;
        for (int i = 0; i < BB; i++) b[W-1-8*i -: 8] = base + 8'(i);
        return b;
    endfunction

    task automatic send_block(input logic [7:0] hdr, input logic [7:0] base, input int nbytes);
        fifo_q.push_back(hdr);
        for (int i = 0; i < nbytes; i++) fifo_q.push_back(base + 8'(i));
    endtask

    task automatic expect_block(input logic [7:0] base, input logic f, input logic l);
        exp_q.push_back(make_block(base));
        exp_first_q.push_back(f);
        exp_last_q.push_back(l);
    endtask

    task automatic wait_acc(input int n, input string tag);
        int k;
        k = 0;
        while (acc_n < n && k < 2000) begin
            tick();
            k++;
        end
        check_eq(tag, W'(acc_n), W'(n));
    endtask

    task automatic wait_err(input int n, input string tag);
        int k;
        k = 0;
        while (err_cyc_q.size() < n && k < 2000) begin
            tick();
            k++;
        end
        check_eq(tag, W'(err_cyc_q.size()), W'(n));
    endtask

    task automatic check_block(input string tag);
        check_eq({tag, "_present"}, W'(acc_data_q.size() > 0 && exp_q.size() > 0), W'(1));
        if (acc_data_q.size() > 0 && exp_q.size() > 0) begin
            check_eq({tag, "_data"}, acc_data_q.pop_front(), exp_q.pop_front());
            check_eq({tag, "_first"}, W'(acc_first_q.pop_front()), W'(exp_first_q.pop_front()));
            check_eq({tag, "_last"}, W'(acc_last_q.pop_front()), W'(exp_last_q.pop_front()));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rd"}, W'(rd_uart), W'(0));
        check_eq({tag, "_valid"}, W'(blk_valid), W'(0));
        check_eq({tag, "_first"}, W'(blk_first), W'(0));
        check_eq({tag, "_last"}, W'(blk_last), W'(0));
        check_eq({tag, "_busy"}, W'(busy), W'(0));
        check_eq({tag, "_err"}, W'(err), W'(0));
        check_eq({tag, "_code"}, W'(err_code), W'(ERR_NONE));
        check_eq({tag, "_data"}, blk_data, W'(0));
        check_eq({tag, "_state"}, W'(dbg_state), W'(S_IDLE));
    endtask

    initial begin
        int rd0;
        int acc0;
        int vr0;
        int err0;
        int unstable;
        logic [W-1:0] blk0;

        // Reset: FIFO non-empty while in reset must not trigger a read.
        fifo_q.push_back(8'hAA);
        repeat (3) tick();
        check_reset_outputs("reset");
        fifo_q.delete();
        repeat (2) tick();
        rd_pending = 1'b0;
        rst = 1'b1;
        tick();

        // Single-block message
        blk_ready = 1'b1;
        rd0 = rd_cyc_q.size();
        vr0 = vrise_q.size();
        send_block(8'h03, 8'h00, BB);
        expect_block(8'h00, 1'b1, 1'b1);
        wait_acc(1, "t1_accept");
        if (acc_data_q.size() > 0) begin
            blk0 = acc_data_q[0];
            check_eq("t1_msb_byte", W'(blk0[W-1 -: 8]), W'(8'h00));
            check_eq("t1_lsb_byte", W'(blk0[7:0]), W'(8'h3F));
        end
        check_block("t1");
        if (vrise_q.size() > vr0 && rd_cyc_q.size() > rd0)
            check_eq("t1_latency", W'(vrise_q[vr0] - rd_cyc_q[rd0]), W'(130));
        else
            check_eq("t1_latency_seen", W'(vrise_q.size()), W'(vr0 + 1));
        check_eq("t1_no_err", W'(err_cyc_q.size()), W'(0));

        // Two-block message with a 50-cycle stall on the first block
        blk_ready = 1'b0;
        rd0 = rd_cyc_q.size();
        vr0 = vrise_q.size();
        acc0 = acc_n;
        send_block(8'h02, 8'h40, BB);
        send_block(8'h01, 8'h80, BB);
        expect_block(8'h40, 1'b1, 1'b0);
        expect_block(8'h80, 1'b0, 1'b1);
        for (int k = 0; k < 1000 && vrise_q.size() == vr0; k++) tick();
        check_eq("t2_valid_rise", W'(vrise_q.size()), W'(vr0 + 1));
        unstable = 0;
        for (int k = 0; k < 50; k++) begin
            if (!blk_valid || blk_data !== exp_q[0] || blk_first !== 1'b1 || blk_last !== 1'b0)
                unstable++;
            tick();
        end
        check_eq("t2_stall_stable", W'(unstable), W'(0));
        check_eq("t2_no_read_in_stall", W'(rd_cyc_q.size()), W'(rd0 + 65));
        blk_ready = 1'b1;
        wait_acc(acc0 + 2, "t2_accept");
        if (rd_cyc_q.size() > rd0 + 65 && acc_cyc_q.size() > acc0)
            check_eq("t2_hdr2_after_accept", W'(rd_cyc_q[rd0 + 65]), W'(acc_cyc_q[acc0] + 1));
        else
            check_eq("t2_hdr2_read", W'(rd_cyc_q.size()), W'(rd0 + 130));
        check_block("t2_b0");
        check_block("t2_b1");
        check_eq("t2_no_err", W'(err_cyc_q.size()), W'(0));

        // Bad header, then a valid block
        acc0 = acc_n;
        vr0 = vrise_q.size();
        send_block(8'h80, 8'h00, 0);
        send_block(8'h03, 8'h10, BB);
        expect_block(8'h10, 1'b1, 1'b1);
        wait_err(1, "t3_err_seen");
        if (err_cyc_q.size() > 0) begin
            check_eq("t3_err_code", W'(err_code_q[0]), W'(ERR_HDR));
            check_eq("t3_err_state", W'(err_state_q[0]), W'(S_IDLE));
            check_eq("t3_err_busy", W'(err_busy_q[0]), W'(0));
        end
        wait_acc(acc0 + 1, "t3_accept");
        check_eq("t3_one_valid", W'(vrise_q.size()), W'(vr0 + 1));
        check_block("t3");

        // Sequence error: continuation header with no message open
        send_block(8'h01, 8'h00, 0);
        wait_err(2, "t4a_err_seen");
        if (err_cyc_q.size() > 1)
            check_eq("t4a_err_code", W'(err_code_q[1]), W'(ERR_SEQ));

        // Sequence error: second first-header while message open
        acc0 = acc_n;
        send_block(8'h02, 8'h20, BB);
        send_block(8'h02, 8'h00, 0);
        expect_block(8'h20, 1'b1, 1'b0);
        wait_err(3, "t4b_err_seen");
        check_eq("t4b_accept", W'(acc_n), W'(acc0 + 1));
        if (err_cyc_q.size() > 2 && acc_cyc_q.size() > acc0) begin
            check_eq("t4b_err_code", W'(err_code_q[2]), W'(ERR_SEQ));
            check_eq("t4b_err_after_block", W'(err_cyc_q[2] > acc_cyc_q[acc0]), W'(1));
        end
        check_block("t4b");

        // Timeout: header plus 10 bytes, then the FIFO stays empty
        acc0 = acc_n;
        vr0 = vrise_q.size();
        send_block(8'h03, 8'h30, 10);
        wait_err(4, "t5_err_seen");
        if (err_cyc_q.size() > 3) begin
            check_eq("t5_err_code", W'(err_code_q[3]), W'(ERR_TIMEOUT));
            check_eq("t5_err_delay", W'(err_cyc_q[3] - (rd_cyc_q[rd_cyc_q.size() - 1] + 1)), W'(100));
            check_eq("t5_err_busy", W'(err_busy_q[3]), W'(0));
        end
        tick();
        check_eq("t5_busy_after", W'(busy), W'(0));
        check_eq("t5_no_block", W'(acc_n), W'(acc0));
        check_eq("t5_no_valid", W'(vrise_q.size()), W'(vr0));

        // Reset at payload byte 30, then a fresh block
        rd0 = rd_cyc_q.size();
        err0 = err_cyc_q.size();
        send_block(8'h03, 8'h55, BB);
        for (int k = 0; k < 500 && rd_cyc_q.size() < rd0 + 31; k++) tick();
        check_eq("t6_reached_byte30", W'(rd_cyc_q.size() >= rd0 + 31), W'(1));
        @(negedge clk);
        #1;
        rst = 1'b0;
        fifo_q.delete();
        rd_pending = 1'b0;
        #1;
        check_reset_outputs("t6_async_rst");
        repeat (3) tick();
        rst = 1'b1;
        tick();
        acc0 = acc_n;
        send_block(8'h03, 8'hA0, BB);
        expect_block(8'hA0, 1'b1, 1'b1);
        wait_acc(acc0 + 1, "t6_accept");
        check_block("t6");
        check_eq("t6_no_err", W'(err_cyc_q.size()), W'(err0));

        check_eq("protocol", W'(proto_bad), W'(0));
        check_eq("scoreboard_empty", W'(exp_q.size()), W'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
